// File: rtl/apb_pkg.sv
// Shared APB definitions: state encoding, default widths and the response record
// used by the initiator and by peripheral wrappers.
package apb_pkg;

    localparam int APB_ADDR_WIDTH_DEF = 12;
    localparam int APB_DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_WIDTH_DEF-1:0] rdata;
        logic                          err;
        logic                          timeout;
    } apb_rsp_t;

    // Wait counter must hold 0..limit; a zero limit still needs one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Request/response handshake plus APB3 bus signals of the initiator.
// Handshake: a request transfers on a rising edge where req_valid_i and req_ready_o are both high;
// rsp_valid_o is a single-cycle pulse with no backpressure.
interface apb_master_if #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32
);
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic                      req_we_i;
    logic [APB_ADDR_WIDTH-1:0] req_addr_i;
    logic [APB_DATA_WIDTH-1:0] req_wdata_i;
    logic                      rsp_valid_o;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      rsp_timeout_o;
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [APB_DATA_WIDTH-1:0] PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [APB_DATA_WIDTH-1:0] PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, PRDATA, PREADY, PSLVERR,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, PRDATA, PREADY, PSLVERR,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

endinterface

// File: rtl/apb_master.sv
// APB3 initiator: one request -> one SETUP/ACCESS transfer -> one response pulse,
// with an optional wait-state timeout so a hung peripheral cannot stall the requester.
module apb_master
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                HCLK,
    input  logic                HRESET,
    apb_master_if.master        bus,
    output logic [1:0]          state_o
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SETUP  = ST_SETUP;
    localparam logic [1:0] S_ACCESS = ST_ACCESS;

    localparam int              CNT_W  = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam bit              TO_EN  = (TIMEOUT_CYCLES != 0);

    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_to_q, rsp_to_d;

    // Saturating increment: the counter never wraps even if the limit is disabled.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    state_d  = S_SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = bus.req_we_i;
                    paddr_d  = bus.req_addr_i;
                    pwdata_d = bus.req_we_i ? bus.req_wdata_i : '0;
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            S_ACCESS: begin
                // PREADY is checked first so a completion on the limit cycle is not aborted.
                if (bus.PREADY) begin
                    state_d     = S_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d   = bus.PSLVERR;
                    rsp_to_d    = 1'b0;
                end else if (TO_EN && (cnt_inc == TO_LIM)) begin
                    state_d     = S_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d   = S_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign bus.req_ready_o   = (state_q == S_IDLE);
    assign bus.PSEL          = psel_q;
    assign bus.PENABLE       = penable_q;
    assign bus.PWRITE        = pwrite_q;
    assign bus.PADDR         = paddr_q;
    assign bus.PWDATA        = pwdata_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_rdata_o   = rsp_rdata_q;
    assign bus.rsp_err_o     = rsp_err_q;
    assign bus.rsp_timeout_o = rsp_to_q;
    assign state_o           = state_q;

endmodule
